// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the FIFO controller slice.
// Provides depth/count-width helpers and default threshold values.
// Optional feature macro used by this slice: FIFO_CTRL_ERR_FLAGS_EN.

// Count is wide enough to hold 0..2**aw inclusive.
`define FIFO_CNT_W(aw) ((aw) + 1)

package fifo_pkg;

    localparam int unsigned DEF_ADDR_WIDTH   = 7;
    localparam int unsigned DEF_AFULL_MARGIN = 2;
    localparam int unsigned DEF_AEMPTY_TH    = 2;

    // Number of entries addressed by an aw-bit pointer.
    function automatic int unsigned fifo_depth(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

endpackage

// File: rtl/fifo_ctrl_if.sv
// Handshake and status bundle between a FIFO parent and fifo_ctrl.
// master: parent (drives wr/rd, observes status and reg_file controls).
// slave : fifo_ctrl (consumes wr/rd, drives we/w_addr/r_addr/count/flags).

interface fifo_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = fifo_pkg::DEF_ADDR_WIDTH
);
    localparam int unsigned CNT_W = `FIFO_CNT_W(ADDR_WIDTH);

    logic                  wr;
    logic                  rd;
    logic                  we;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  full;
    logic                  empty;
    logic [CNT_W-1:0]      count;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr, rd,
        input  we, w_addr, r_addr, full, empty, count,
               almost_full, almost_empty, overflow, underflow
    );

    modport slave (
        input  wr, rd,
        output we, w_addr, r_addr, full, empty, count,
               almost_full, almost_empty, overflow, underflow
    );
endinterface

// File: rtl/fifo_ptr.sv
// Wrapping ADDR_WIDTH-bit pointer with synchronous reset and increment enable.
// Ports: clk, reset (sync, active-high), inc (advance by one), ptr (registered value).

module fifo_ptr #(
    parameter int unsigned ADDR_WIDTH = fifo_pkg::DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inc,
    output logic [ADDR_WIDTH-1:0] ptr
);

    // Natural binary overflow gives the modulo-depth wrap.
    always_ff @(posedge clk) begin
        if (reset)
            ptr <= '0;
        else if (inc)
            ptr <= ptr + ADDR_WIDTH'(1);
    end

endmodule

// File: rtl/fifo_ctrl.sv
// Pointer/flag controller turning a dual-port reg_file into a circular FIFO.
// Ports: clk, reset (sync, active-high), bus (fifo_ctrl_if.slave):
//   wr/rd requests in; we, w_addr, r_addr to reg_file; count and
//   full/empty/almost_full/almost_empty status; sticky overflow/underflow.
// Macro FIFO_CTRL_ERR_FLAGS_EN enables the sticky error flags; otherwise
// overflow/underflow are constant 0.

module fifo_ctrl #(
    parameter int unsigned ADDR_WIDTH = fifo_pkg::DEF_ADDR_WIDTH,
    parameter int unsigned AFULL_TH   = fifo_pkg::fifo_depth(ADDR_WIDTH) - fifo_pkg::DEF_AFULL_MARGIN,
    parameter int unsigned AEMPTY_TH  = fifo_pkg::DEF_AEMPTY_TH
) (
    input  logic         clk,
    input  logic         reset,
    fifo_ctrl_if.slave   bus
);
    import fifo_pkg::*;

    localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);
    localparam int unsigned CNT_W = `FIFO_CNT_W(ADDR_WIDTH);

    logic                  push_ok;
    logic                  pop_ok;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_nxt;
    logic                  full_q;
    logic                  empty_q;
    logic                  afull_q;
    logic                  aempty_q;
    logic [ADDR_WIDTH-1:0] w_ptr;
    logic [ADDR_WIDTH-1:0] r_ptr;

    // Accept decisions use registered flags only; a pop frees the slot a
    // simultaneous push needs when full.
    always_comb begin
        push_ok   = bus.wr & (~full_q | bus.rd);
        pop_ok    = bus.rd & ~empty_q;
        count_nxt = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_nxt = count_q + CNT_W'(1);
            2'b01:   count_nxt = count_q - CNT_W'(1);
            default: count_nxt = count_q;
        endcase
    end

    // Reset drops any push presented in the same cycle, so no write reaches reg_file.
    assign bus.we = push_ok & ~reset;

    fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_w_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (push_ok),
        .ptr   (w_ptr)
    );

    fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_r_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (pop_ok),
        .ptr   (r_ptr)
    );

    // Occupancy and status flags, all registered from next-state count.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
        end else begin
            count_q  <= count_nxt;
            full_q   <= (count_nxt == CNT_W'(DEPTH));
            empty_q  <= (count_nxt == '0);
            afull_q  <= (count_nxt >= CNT_W'(AFULL_TH));
            aempty_q <= (count_nxt <= CNT_W'(AEMPTY_TH));
        end
    end

`ifdef FIFO_CTRL_ERR_FLAGS_EN
    logic overflow_q;
    logic underflow_q;

    // Sticky error flags: refused push when full, pop attempt when empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (bus.wr & full_q & ~bus.rd)
                overflow_q <= 1'b1;
            if (bus.rd & empty_q)
                underflow_q <= 1'b1;
        end
    end

    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
`else
    assign bus.overflow  = 1'b0;
    assign bus.underflow = 1'b0;
`endif

    assign bus.w_addr       = w_ptr;
    assign bus.r_addr       = r_ptr;
    assign bus.count        = count_q;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = afull_q;
    assign bus.almost_empty = aempty_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl (ADDR_WIDTH=2, AFULL_TH=3, AEMPTY_TH=1)
// paired with a small behavioural reg_file; reference model is a data queue.

module tb_fifo_ctrl;

    localparam int unsigned AW    = 2;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned AF_TH = 3;
    localparam int unsigned AE_TH = 1;

`ifdef FIFO_CTRL_ERR_FLAGS_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic [7:0] data_w;
    logic [7:0] data_r;
    logic [7:0] mem [DEPTH];

    int tests_run;
    int tests_failed;

    // Reference model state.
    logic [7:0] q[$];
    int unsigned wr_total;
    int unsigned rd_total;
    bit m_ovf;
    bit m_unf;

    fifo_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    fifo_ctrl #(
        .ADDR_WIDTH (AW),
        .AFULL_TH   (AF_TH),
        .AEMPTY_TH  (AE_TH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural reg_file: synchronous write, asynchronous read.
    always @(posedge clk) begin
        if (bus.we === 1'b1)
            mem[bus.w_addr] <= data_w;
    end
    assign data_r = mem[bus.r_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        chk("count",        32'(bus.count),        32'(q.size()));
        chk("empty",        32'(bus.empty),        32'(q.size() == 0));
        chk("full",         32'(bus.full),         32'(q.size() == DEPTH));
        chk("almost_full",  32'(bus.almost_full),  32'(q.size() >= AF_TH));
        chk("almost_empty", 32'(bus.almost_empty), 32'(q.size() <= AE_TH));
        chk("w_addr",       32'(bus.w_addr),       wr_total % DEPTH);
        chk("r_addr",       32'(bus.r_addr),       rd_total % DEPTH);
        chk("overflow",     32'(bus.overflow),     32'(m_ovf));
        chk("underflow",    32'(bus.underflow),    32'(m_unf));
    endtask

    // One clock: drive at negedge, check combinational outputs, update model at
    // the edge, check registered outputs just after it.
    task automatic step(input bit rs, input bit w, input bit r, input logic [7:0] d);
        bit is_full;
        bit exp_push;
        bit exp_pop;
        @(negedge clk);
        reset  = rs;
        bus.wr = w;
        bus.rd = r;
        data_w = d;
        #1;
        is_full  = (q.size() == DEPTH);
        exp_push = !rs && w && (!is_full || r);
        exp_pop  = !rs && r && (q.size() != 0);
        chk("we", 32'(bus.we), 32'(exp_push));
        if (exp_pop)
            chk("data_r", 32'(data_r), 32'(q[0]));
        @(posedge clk);
        if (rs) begin
            q.delete();
            wr_total = 0;
            rd_total = 0;
            m_ovf    = 1'b0;
            m_unf    = 1'b0;
        end else begin
            if (ERR_EN && w && is_full && !r) m_ovf = 1'b1;
            if (ERR_EN && r && q.size() == 0) m_unf = 1'b1;
            if (exp_pop) void'(q.pop_front());
            if (exp_push) q.push_back(d);
            wr_total += 32'(exp_push);
            rd_total += 32'(exp_pop);
        end
        #1;
        check_state();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        wr_total     = 0;
        rd_total     = 0;
        m_ovf        = 1'b0;
        m_unf        = 1'b0;
        reset        = 1'b1;
        bus.wr       = 1'b0;
        bus.rd       = 1'b0;
        data_w       = 8'h00;

        // 1: reset then fill with four pushes.
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h11);
        step(1'b0, 1'b1, 1'b0, 8'h22);
        step(1'b0, 1'b1, 1'b0, 8'h33);
        chk("afull_at_3", 32'(bus.almost_full), 32'd1);
        step(1'b0, 1'b1, 1'b0, 8'h44);
        chk("full_at_4", 32'(bus.full), 32'd1);
        chk("w_wrapped", 32'(bus.w_addr), 32'd0);

        // 2: push while full is refused.
        step(1'b0, 1'b1, 1'b0, 8'h55);
        chk("count_after_ovf", 32'(bus.count), 32'd4);

        // 3: push+pop while full replaces the slot being read.
        step(1'b0, 1'b1, 1'b1, 8'h66);
        chk("slot0_rewritten", 32'(mem[0]), 32'h66);

        // 4: drain, then an extra pop on empty.
        repeat (4) step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("empty_after_drain", 32'(bus.empty), 32'd1);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("r_addr_held", 32'(bus.r_addr), 32'd1);

        // 5: push+pop on empty is push only.
        step(1'b0, 1'b1, 1'b1, 8'h77);
        chk("head_is_77", 32'(data_r), 32'h77);

        // 6: reset mid-stream with count=3 and both requests high.
        step(1'b0, 1'b1, 1'b0, 8'h88);
        step(1'b0, 1'b1, 1'b0, 8'h99);
        chk("count_before_rst", 32'(bus.count), 32'd3);
        step(1'b1, 1'b1, 1'b1, 8'hAA);
        chk("count_after_rst", 32'(bus.count), 32'd0);
        step(1'b0, 1'b0, 1'b0, 8'h00);

        // Randomised traffic with alternating fill/drain bias and rare resets.
        for (int i = 0; i < 600; i++) begin
            bit rs;
            bit w;
            bit r;
            int unsigned wp;
            wp = ((i / 40) % 2 == 0) ? 75 : 25;
            rs = ($urandom_range(0, 99) == 0);
            w  = ($urandom_range(0, 99) < wp);
            r  = ($urandom_range(0, 99) < (100 - wp));
            step(rs, w, r, 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
